// File: rtl/controle_batalha.sv
// Turn controller for the 5x7 LED battleship game: button debounce, attack decode,
// shot/hit history and result LEDs. Optional shot limit enabled by LIMITE_TIROS_EN.
module controle_batalha #(
  parameter int DEB_CICLOS    = 4,
  parameter int RESULT_CICLOS = 8,
  parameter int ALVOS         = 6,
  parameter int MAX_TIROS     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        botao,
  input  logic [7:0]  ch,
  input  logic [34:0] pos_matriz,
  output logic        pos_trava,
  output logic [34:0] atq_hist,
  output logic [34:0] acerto_hist,
  output logic [5:0]  acertos,
  output logic [5:0]  tiros,
  output logic [2:0]  fase,
  output logic        verde,
  output logic        vermelho
);

  // state   | meaning
  // POSIC   | players place ships, matrix unlocked
  // ESPERA  | waiting for an attack command
  // AVALIA  | single cycle: record shot and score it
  // MOSTRA  | result shown on the LEDs for RESULT_CICLOS cycles
  // VITORIA | all targets hit, green steady
  // DERROTA | shot limit reached, red steady
  typedef enum logic [2:0] {
    POSIC   = 3'd0,
    ESPERA  = 3'd1,
    AVALIA  = 3'd2,
    MOSTRA  = 3'd3,
    VITORIA = 3'd4,
    DERROTA = 3'd5
  } fase_t;

  localparam int DW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
  localparam int RW = (RESULT_CICLOS > 1) ? $clog2(RESULT_CICLOS) : 1;

  fase_t         fase_q, fase_d;
  logic          sync1, sync2, deb, deb_prev;
  logic [DW-1:0] deb_cnt;
  logic [RW-1:0] res_cnt;
  logic [5:0]    idx_q;
  logic          res_hit;
  logic          cmd;
  logic [2:0]    row, col;
  logic          coord_ok, repete, fim_mostra, limite;
  logic [5:0]    idx_calc;
  logic          unused_ch;

  assign unused_ch = ch[6];
  assign cmd       = deb & ~deb_prev;

  assign row        = ch[2:0];
  assign col        = ch[5:3];
  assign coord_ok   = (row <= 3'd6) && (col <= 3'd4);
  assign idx_calc   = {3'b000, row} * 6'd5 + {3'b000, col};
  assign repete     = coord_ok && atq_hist[idx_calc];
  assign fim_mostra = (res_cnt == '0);

`ifdef LIMITE_TIROS_EN
  assign limite = (tiros == 6'(MAX_TIROS));
`else
  logic unused_max;
  assign unused_max = (MAX_TIROS > 0);
  assign limite     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fase_q <= POSIC;
    else     fase_q <= fase_d;
  end

  always_comb begin
    fase_d = fase_q;
    case (fase_q)
      POSIC:   if (cmd && ch[7]) fase_d = ESPERA;
      ESPERA:  if (cmd) fase_d = (!coord_ok || repete) ? MOSTRA : AVALIA;
      AVALIA:  fase_d = MOSTRA;
      MOSTRA:
        if (fim_mostra) begin
          if (acertos == 6'(ALVOS)) fase_d = VITORIA;
          else if (limite)          fase_d = DERROTA;
          else                      fase_d = ESPERA;
        end
      VITORIA, DERROTA: if (cmd && ch[7]) fase_d = POSIC;
      default: fase_d = POSIC;
    endcase
  end

  always_comb begin
    pos_trava = (fase_q != POSIC);
    verde     = ((fase_q == MOSTRA) && res_hit) || (fase_q == VITORIA);
    vermelho  = ((fase_q == MOSTRA) && !res_hit) || (fase_q == DERROTA);
    fase      = fase_q;
  end

  // Debounce: down-counter reloads while the synchronized level matches, flips at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      deb      <= 1'b0;
      deb_prev <= 1'b0;
      deb_cnt  <= DW'(DEB_CICLOS - 1);
    end else begin
      sync1    <= botao;
      sync2    <= sync1;
      deb_prev <= deb;
      if (sync2 == deb) begin
        deb_cnt <= DW'(DEB_CICLOS - 1);
      end else if (deb_cnt == '0) begin
        deb     <= sync2;
        deb_cnt <= DW'(DEB_CICLOS - 1);
      end else begin
        deb_cnt <= deb_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      atq_hist    <= '0;
      acerto_hist <= '0;
      acertos     <= '0;
      tiros       <= '0;
      idx_q       <= '0;
      res_hit     <= 1'b0;
      res_cnt     <= '0;
    end else begin
      case (fase_q)
        ESPERA:
          if (cmd) begin
            idx_q   <= idx_calc;
            res_hit <= 1'b0;
            res_cnt <= RW'(RESULT_CICLOS - 1);
          end
        AVALIA: begin
          atq_hist[idx_q] <= 1'b1;
          if (tiros != 6'd63) tiros <= tiros + 1'b1;
          res_hit <= pos_matriz[idx_q];
          res_cnt <= RW'(RESULT_CICLOS - 1);
          if (pos_matriz[idx_q]) begin
            acerto_hist[idx_q] <= 1'b1;
            if (acertos != 6'd63) acertos <= acertos + 1'b1;
          end
        end
        MOSTRA:
          if (!fim_mostra) res_cnt <= res_cnt - 1'b1;
        VITORIA, DERROTA:
          if (cmd && ch[7]) begin
            atq_hist    <= '0;
            acerto_hist <= '0;
            acertos     <= '0;
            tiros       <= '0;
            res_hit     <= 1'b0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_batalha.sv
// Bench for controle_batalha: directed game scenarios plus random games scored by
// a cell-array model of the rules. Build with LIMITE_TIROS_EN to exercise defeat.
module tb_controle_batalha;

  localparam int DEB  = 4;
  localparam int RES  = 8;
  localparam int ALV  = 2;
  localparam int MAXT = 3;
`ifdef LIMITE_TIROS_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic        clk, rst, botao;
  logic [7:0]  ch;
  logic [34:0] pos_matriz;
  logic        pos_trava, verde, vermelho;
  logic [34:0] atq_hist, acerto_hist;
  logic [5:0]  acertos, tiros;
  logic [2:0]  fase;

  controle_batalha #(
    .DEB_CICLOS(DEB), .RESULT_CICLOS(RES), .ALVOS(ALV), .MAX_TIROS(MAXT)
  ) dut (
    .clk(clk), .rst(rst), .botao(botao), .ch(ch), .pos_matriz(pos_matriz),
    .pos_trava(pos_trava), .atq_hist(atq_hist), .acerto_hist(acerto_hist),
    .acertos(acertos), .tiros(tiros), .fase(fase), .verde(verde), .vermelho(vermelho)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  bit m_atq[35];
  bit m_hit[35];
  int m_nh, m_ns, m_fase;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 35; i++) begin m_atq[i] = 0; m_hit[i] = 0; end
    m_nh = 0; m_ns = 0; m_fase = 0;
  endtask

  function automatic logic [34:0] mvec(input bit hits);
    logic [34:0] v;
    for (int i = 0; i < 35; i++) v[i] = hits ? m_hit[i] : m_atq[i];
    return v;
  endfunction

  // Expected green/red LED-on cycles over the 28-cycle press window.
  task automatic model_cmd(input logic [7:0] c, output int eg, output int er);
    int r, k, i;
    eg = 0; er = 0;
    r = int'(c[2:0]); k = int'(c[5:3]);
    case (m_fase)
      0: if (c[7]) m_fase = 1;
      1: begin
        if (r > 6 || k > 4) er = RES;
        else begin
          i = r * 5 + k;
          if (m_atq[i]) er = RES;
          else begin
            m_atq[i] = 1;
            if (m_ns < 63) m_ns++;
            if (pos_matriz[i]) begin
              m_hit[i] = 1;
              if (m_nh < 63) m_nh++;
              eg = RES;
            end else er = RES;
            if (m_nh == ALV) begin m_fase = 4; eg += 13; end
            else if (LIM && m_ns == MAXT) begin m_fase = 5; er += 13; end
          end
        end
      end
      4: if (c[7]) begin eg = 6; model_reset(); end else eg = 28;
      5: if (c[7]) begin er = 6; model_reset(); end else er = 28;
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".fase"}, 64'(fase), 64'(m_fase));
    chk({tag, ".trava"}, 64'(pos_trava), 64'(m_fase != 0));
    chk({tag, ".atq"}, 64'(atq_hist), 64'(mvec(0)));
    chk({tag, ".acerto"}, 64'(acerto_hist), 64'(mvec(1)));
    chk({tag, ".acertos"}, 64'(acertos), 64'(m_nh));
    chk({tag, ".tiros"}, 64'(tiros), 64'(m_ns));
  endtask

  task automatic do_cmd(input logic [7:0] c, input string tag);
    int g, r, eg, er;
    model_cmd(c, eg, er);
    g = 0; r = 0;
    @(negedge clk);
    ch = c; botao = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      g += int'(verde); r += int'(vermelho);
      if (k == 8) botao = 1'b0;
    end
    chk({tag, ".verde_cyc"}, 64'(g), 64'(eg));
    chk({tag, ".verm_cyc"}, 64'(r), 64'(er));
    check_state(tag);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [7:0] cell_ch(input int i);
    logic [2:0] r3, k3;
    r3 = 3'(i / 5); k3 = 3'(i % 5);
    return {1'b0, 1'($urandom_range(0, 1)), k3, r3};
  endfunction

  function automatic logic [7:0] rand_shot();
    int sel, i, tries;
    logic [2:0] r3, k3;
    sel = int'($urandom_range(0, 9));
    if (sel < 2) begin
      if ($urandom_range(0, 1) == 1) begin r3 = 3'd7; k3 = 3'($urandom_range(0, 7)); end
      else begin r3 = 3'($urandom_range(0, 7)); k3 = 3'($urandom_range(5, 7)); end
      return {1'b0, 1'($urandom_range(0, 1)), k3, r3};
    end
    tries = 0;
    i = int'($urandom_range(0, 34));
    if (sel < 4) begin
      while (!m_atq[i] && tries < 100) begin i = int'($urandom_range(0, 34)); tries++; end
    end else if (sel < 7) begin
      while (!pos_matriz[i] && tries < 100) begin i = int'($urandom_range(0, 34)); tries++; end
    end
    return cell_ch(i);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nships;
    rst = 1'b1; botao = 1'b0; ch = 8'h00; pos_matriz = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset.verde", 64'(verde), 64'd0);
    chk("reset.verm", 64'(vermelho), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Too-short press: 3 cycles must not produce a command
    pos_matriz = 35'(1) << 7 | 35'(1);
    ch = 8'h80; botao = 1'b1;
    repeat (3) @(negedge clk);
    botao = 1'b0;
    repeat (20) @(negedge clk);
    chk("short_press.fase", 64'(fase), 64'd0);

    do_cmd(8'h0A, "posic_no_confirm");

    // Shortest accepted press: 4 cycles
    ch = 8'h80; botao = 1'b1;
    repeat (4) @(negedge clk);
    botao = 1'b0;
    repeat (20) @(negedge clk);
    m_fase = 1;
    check_state("min_press");

    do_cmd(8'h0A, "miss_idx11");
    do_cmd(8'h0A, "repeat_idx11");
    do_cmd(8'h11, "hit_idx7");
    do_cmd(8'h28, "invalid_col5");
    do_cmd(8'h00, "hit_idx0_win");
    do_cmd(8'h0A, "vitoria_ignore");
    do_cmd(8'h80, "restart_a");

    pos_matriz = 35'b11;
    do_cmd(8'h80, "confirm_b");
    do_cmd(8'h26, "miss_idx34");
    do_cmd(8'h25, "miss_idx29");
    do_cmd(8'h24, "miss_idx24");
    do_cmd(8'h00, "shot_idx0");
    do_cmd(8'h08, "shot_idx1");
    do_cmd(8'h80, "restart_b");

    // Asynchronous reset while a result is on the LEDs
    do_cmd(8'h80, "confirm_c");
    @(negedge clk);
    ch = 8'h26; botao = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_rst.verm", 64'(vermelho), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst.fase", 64'(fase), 64'd0);
    chk("async_rst.verm", 64'(vermelho), 64'd0);
    chk("async_rst.trava", 64'(pos_trava), 64'd0);
    chk("async_rst.atq", 64'(atq_hist), 64'd0);
    chk("async_rst.tiros", 64'(tiros), 64'd0);
    botao = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);
    check_state("post_rst");

    for (int g = 0; g < 6; g++) begin
      pulse_reset();
      pos_matriz = '0;
      nships = int'($urandom_range(2, 6));
      for (int s = 0; s < nships; s++) pos_matriz[$urandom_range(0, 34)] = 1'b1;
      do_cmd(8'h80, "rnd_confirm");
      for (int s = 0; s < 12; s++) begin
        if (m_fase >= 4) break;
        do_cmd(rand_shot(), "rnd_shot");
      end
      if (m_fase >= 4) do_cmd(8'h80, "rnd_restart");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
